// File: rtl/mem_8x6144_burst_master.sv
// Burst engine for an 8x6144 synchronous block RAM. One command at a time is
// streamed byte-per-cycle; a 2-entry buffer absorbs the one-cycle read latency.
module mem_8x6144_burst_master #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 13,
   parameter int LEN_W     = 13,
   parameter int MEM_DEPTH = 6144
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_WRITE,
   input  logic [ADDR_W-1:0] CMD_ADDR,
   input  logic [LEN_W-1:0]  CMD_LEN,
   input  logic [DATA_W-1:0] WR_DATA,
   input  logic              WR_VALID,
   output logic              WR_READY,
   output logic [DATA_W-1:0] RD_DATA,
   output logic              RD_VALID,
   input  logic              RD_READY,
   output logic              DONE,
   output logic              ERR,
   output logic [DATA_W-1:0] MEM_DI,
   output logic              MEM_DIP,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic              MEM_EN,
   output logic              MEM_WE,
   output logic              MEM_SSR,
   input  logic [DATA_W-1:0] MEM_DO
);

   localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(MEM_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WRITE, S_READ, S_FIN} state_t;

   state_t                  state_q, state_d;
   logic                    wr_q, wr_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [LEN_W-1:0]        rem_q, rem_d;
   logic [1:0][DATA_W-1:0]  buf_q, buf_d;
   logic                    rd_ptr_q, rd_ptr_d;
   logic                    wr_ptr_q, wr_ptr_d;
   logic [1:0]              cnt_q, cnt_d;
   logic                    infl_q, infl_d;
   logic                    live_q;

   logic [LEN_W:0]          end_sum;
   logic                    rd_vld;
   logic                    pop;
   logic [1:0]              occ;
   logic                    issue;

   assign end_sum = (LEN_W+1)'(addr_q) + (LEN_W+1)'(rem_q);
   assign rd_vld  = (cnt_q != 2'd0);
   assign pop     = rd_vld & RD_READY;
   // Occupancy after this cycle's pop; a read may issue only if it still fits.
   assign occ     = cnt_q + {1'b0, infl_q} - {1'b0, pop};
   assign issue   = (state_q == S_READ) && (rem_q != '0) && (occ < 2'd2);

   assign RD_VALID = rd_vld;
   assign RD_DATA  = rd_vld ? buf_q[rd_ptr_q] : '0;
   assign MEM_DIP  = ^MEM_DI;
   assign MEM_SSR  = 1'b0;

   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      infl_d    = 1'b0;
      CMD_READY = 1'b0;
      WR_READY  = 1'b0;
      MEM_EN    = 1'b0;
      MEM_WE    = 1'b0;
      MEM_ADDR  = '0;
      MEM_DI    = '0;
      DONE      = 1'b0;
      ERR       = 1'b0;

      case (state_q)
         S_IDLE: begin
            CMD_READY = live_q;
            if (CMD_VALID && live_q) begin
               wr_d    = CMD_WRITE;
               addr_d  = CMD_ADDR;
               rem_d   = CMD_LEN;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (rem_q == '0 || end_sum > DEPTH_L) begin
               ERR     = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = wr_q ? S_WRITE : S_READ;
            end
         end
         S_WRITE: begin
            WR_READY = 1'b1;
            MEM_EN   = WR_VALID;
            MEM_WE   = WR_VALID;
            MEM_ADDR = addr_q;
            MEM_DI   = WR_DATA;
            if (WR_VALID) begin
               addr_d = addr_q + ADDR_W'(1);
               rem_d  = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) state_d = S_FIN;
            end
         end
         S_READ: begin
            if (issue) begin
               MEM_EN   = 1'b1;
               MEM_ADDR = addr_q;
               addr_d   = addr_q + ADDR_W'(1);
               rem_d    = rem_q - LEN_W'(1);
               infl_d   = 1'b1;
            end
            if (rem_q == '0 && !infl_q && cnt_q == 2'd0) state_d = S_FIN;
         end
         S_FIN: begin
            DONE    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Read return path: data issued last cycle lands in the buffer now.
   always_comb begin
      buf_d    = buf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (infl_q) begin
         buf_d[wr_ptr_q] = MEM_DO;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         rem_q    <= '0;
         buf_q    <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         infl_q   <= 1'b0;
         live_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         buf_q    <= buf_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         infl_q   <= infl_d;
         live_q   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_8x6144_burst_master.sv
// Directed bench for mem_8x6144_burst_master with a behavioural sync-read RAM
// and a negedge monitor that logs memory accesses and stream handshakes.
module tb_mem_8x6144_burst_master;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
   logic [12:0] CMD_ADDR = '0, CMD_LEN = '0;
   logic [7:0]  WR_DATA = '0;
   logic        WR_VALID = 1'b0, WR_READY;
   logic [7:0]  RD_DATA;
   logic        RD_VALID, RD_READY = 1'b0;
   logic        DONE, ERR;
   logic [7:0]  MEM_DI;
   logic        MEM_DIP;
   logic [12:0] MEM_ADDR;
   logic        MEM_EN, MEM_WE, MEM_SSR;
   logic [7:0]  MEM_DO = '0;

   mem_8x6144_burst_master dut (
      .CLK(CLK), .RST_N(RST_N),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
      .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
      .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
      .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
      .DONE(DONE), .ERR(ERR),
      .MEM_DI(MEM_DI), .MEM_DIP(MEM_DIP), .MEM_ADDR(MEM_ADDR),
      .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_SSR(MEM_SSR), .MEM_DO(MEM_DO)
   );

   always #5 CLK = ~CLK;

   logic [7:0] mem [6144];
   int tot = 0, bad = 0, cyc = 0;

   function automatic logic [7:0] pv(input int a);
      return 8'(a * 7 + 3);
   endfunction

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (MEM_EN) begin
         if (MEM_WE) mem[MEM_ADDR] <= MEM_DI;
         else        MEM_DO <= mem[MEM_ADDR];
      end
   end

   // monitor logs
   int en_cnt, done_cnt, err_cnt, out_cnt, max_out, first_rd;
   logic [12:0] ea_q[$];
   logic [7:0]  wd_q[$], rd_q[$];
   logic        dip_q[$];
   int          rc_q[$];

   task automatic clr();
      en_cnt = 0; done_cnt = 0; err_cnt = 0; out_cnt = 0; max_out = 0; first_rd = -1;
      ea_q.delete(); wd_q.delete(); rd_q.delete(); dip_q.delete(); rc_q.delete();
   endtask

   always @(negedge CLK) begin
      if (MEM_EN) begin
         en_cnt++;
         ea_q.push_back(MEM_ADDR);
         if (MEM_WE) begin
            wd_q.push_back(MEM_DI);
            dip_q.push_back(MEM_DIP);
         end
      end
      if (RD_VALID && first_rd < 0) first_rd = cyc;
      if (RD_VALID && RD_READY) begin
         rd_q.push_back(RD_DATA);
         rc_q.push_back(cyc);
      end
      out_cnt = out_cnt + int'(MEM_EN && !MEM_WE) - int'(RD_VALID && RD_READY);
      if (out_cnt > max_out) max_out = out_cnt;
      if (DONE) done_cnt++;
      if (ERR)  err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tot++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   int hs_cyc;
   task automatic send_cmd(input logic w, input int a, input int l);
      int n = 0;
      @(posedge CLK); #1;
      CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADDR = 13'(a); CMD_LEN = 13'(l);
      forever begin
         @(negedge CLK);
         if (CMD_READY) break;
         n++;
         if (n > 50) begin
            chk("cmd_timeout", 32'(n), 0);
            break;
         end
      end
      @(posedge CLK); #1;
      hs_cyc = cyc;
      CMD_VALID = 1'b0;
   endtask

   logic [7:0] wd [8];
   bit         vp [8];
   int         np;

   task automatic wr_stream(input int n);
      int i = 0, k = 0;
      while (i < n && k < 100) begin
         @(posedge CLK); #1;
         WR_VALID = vp[k % np];
         WR_DATA  = wd[i];
         @(negedge CLK);
         if (WR_VALID && WR_READY) i++;
         k++;
      end
      @(posedge CLK); #1;
      WR_VALID = 1'b0;
      chk("wr_accepted", 32'(i), 32'(n));
   endtask

   task automatic rd_stream(input int n);
      int k = 0;
      while (rd_q.size() < n && k < 100) begin
         @(posedge CLK); #1;
         RD_READY = vp[k % np];
         @(negedge CLK);
         k++;
      end
      chk("rd_count", 32'(rd_q.size()), 32'(n));
   endtask

   task automatic wait_done();
      int k = 0;
      while (done_cnt == 0 && k < 20) begin
         @(negedge CLK);
         k++;
      end
      repeat (2) @(negedge CLK);
      chk("done_pulse", 32'(done_cnt), 1);
   endtask

   initial begin
      int d0, e0;
      for (int i = 0; i < 6144; i++) mem[i] = pv(i);
      clr();

      // reset state
      #12;
      chk("rst_ready", {30'd0, CMD_READY, WR_READY}, 0);
      chk("rst_rd", {23'd0, RD_VALID, RD_DATA}, 0);
      chk("rst_pulse", {30'd0, DONE, ERR}, 0);
      chk("rst_mem", {8'd0, MEM_EN, MEM_WE, MEM_SSR, MEM_ADDR, MEM_DI}, 0);
      @(posedge CLK); #1; RST_N = 1'b1;

      // write A0..A3 at 0
      clr();
      for (int i = 0; i < 4; i++) wd[i] = 8'hA0 + 8'(i);
      vp[0] = 1; np = 1;
      send_cmd(1'b1, 0, 4);
      wr_stream(4);
      wait_done();
      chk("wr_en_cnt", 32'(en_cnt), 4);
      for (int i = 0; i < 4 && i < ea_q.size() && i < wd_q.size(); i++) begin
         chk("wr_addr", 32'(ea_q[i]), 32'(i));
         chk("wr_data", 32'(wd_q[i]), 32'(8'hA0 + 8'(i)));
      end
      if (dip_q.size() == 4) chk("wr_dip", {28'd0, dip_q[0], dip_q[1], dip_q[2], dip_q[3]}, 32'b0110);
      else chk("wr_dip_size", 32'(dip_q.size()), 4);
      chk("wr_err", 32'(err_cnt), 0);

      // read back with RD_READY held high
      clr();
      RD_READY = 1'b1; vp[0] = 1; np = 1;
      send_cmd(1'b0, 0, 4);
      rd_stream(4);
      wait_done();
      for (int i = 0; i < rd_q.size(); i++) chk("rd_data", 32'(rd_q[i]), 32'(8'hA0 + 8'(i)));
      chk("rd_latency", 32'(first_rd - hs_cyc), 3);
      if (rc_q.size() == 4) chk("rd_back2back", 32'(rc_q[3] - rc_q[0]), 3);

      // read across 0x800 with a 1,0,0,1 ready pattern
      clr();
      vp[0] = 1; vp[1] = 0; vp[2] = 0; vp[3] = 1; np = 4;
      send_cmd(1'b0, 13'h7FE, 4);
      rd_stream(4);
      RD_READY = 1'b1;
      wait_done();
      for (int i = 0; i < rd_q.size(); i++) chk("rdx_data", 32'(rd_q[i]), 32'(pv(13'h7FE + i)));
      for (int i = 0; i < ea_q.size(); i++) chk("rdx_addr", 32'(ea_q[i]), 32'(13'h7FE + i));
      chk("rdx_outstanding_le2", 32'(max_out <= 2), 1);
      chk("rdx_en_cnt", 32'(en_cnt), 4);

      // top-boundary write, legal
      clr();
      for (int i = 0; i < 4; i++) wd[i] = 8'h30 + 8'(i);
      vp[0] = 1; np = 1;
      send_cmd(1'b1, 6140, 4);
      wr_stream(4);
      wait_done();
      chk("bnd_en_cnt", 32'(en_cnt), 4);
      if (ea_q.size() > 0) chk("bnd_last_addr", 32'(ea_q[ea_q.size()-1]), 6143);
      chk("bnd_err", 32'(err_cnt), 0);

      // one past the top: rejected
      clr();
      send_cmd(1'b0, 6141, 4);
      repeat (6) @(negedge CLK);
      chk("oob_err", 32'(err_cnt), 1);
      chk("oob_en", 32'(en_cnt), 0);
      chk("oob_done", 32'(done_cnt), 0);

      // zero length: rejected
      clr();
      send_cmd(1'b1, 16, 0);
      repeat (6) @(negedge CLK);
      chk("len0_err", 32'(err_cnt), 1);
      chk("len0_en", 32'(en_cnt), 0);

      // write with WR_VALID gaps
      clr();
      for (int i = 0; i < 3; i++) wd[i] = 8'h50 + 8'(i);
      vp[0] = 1; vp[1] = 0; vp[2] = 0; vp[3] = 1; vp[4] = 1; np = 5;
      send_cmd(1'b1, 13'h100, 3);
      wr_stream(3);
      wait_done();
      chk("gap_en_cnt", 32'(en_cnt), 3);
      for (int i = 0; i < ea_q.size(); i++) chk("gap_addr", 32'(ea_q[i]), 32'(13'h100 + i));
      if (wd_q.size() == 3) chk("gap_data", {8'd0, wd_q[0], wd_q[1], wd_q[2]}, 32'h505152);

      // reset in the middle of a read
      clr();
      RD_READY = 1'b1; vp[0] = 1; np = 1;
      send_cmd(1'b0, 13'h200, 8);
      begin
         int k = 0;
         while (rd_q.size() < 2 && k < 40) begin
            @(negedge CLK);
            k++;
         end
      end
      chk("mid_got2", 32'(rd_q.size()), 2);
      #2; RST_N = 1'b0; #1;
      chk("mid_rst_out", {14'd0, CMD_READY, WR_READY, RD_VALID, DONE, ERR, MEM_EN, MEM_WE, MEM_SSR}, 0);
      chk("mid_rst_bus", {3'd0, RD_DATA, MEM_ADDR, MEM_DI}, 0);
      d0 = done_cnt; e0 = err_cnt;
      repeat (3) @(negedge CLK);
      chk("mid_no_pulse", 32'(done_cnt + err_cnt), 32'(d0 + e0));
      @(posedge CLK); #1; RST_N = 1'b1;
      clr();
      send_cmd(1'b0, 13'h7FE, 1);
      rd_stream(1);
      wait_done();
      if (rd_q.size() == 1) chk("post_rst_data", 32'(rd_q[0]), 32'(pv(13'h7FE)));
      chk("post_rst_err", 32'(err_cnt), 0);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
